// File: rtl/out_port_uart.sv
// out_port_uart: watches a 16-bit result bus, captures each new value into a
// small FIFO and sends every captured word over a UART line as two frames,
// high byte first, with no gap between frames or between words.
//
// Optional feature macro: OUT_PORT_UART_PARITY_EN
//   defined   -> even-parity bit after the data bits (11-bit frames)
//   undefined -> 8N1 (10-bit frames)
//
// Parameters:
//   DEPTH        FIFO depth in words (power of two, >= 2)
//   CLKS_PER_BIT clock cycles per UART bit (>= 2)
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   data_in      result bus being watched
//   en           capture enable
//   tx           UART line, idle high
//   busy         FIFO non-empty or frame in progress
//   fifo_full    FIFO holds DEPTH words
//   fifo_count   words currently stored
//   overflow     sticky: a capture was dropped because the FIFO was full
module out_port_uart #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             data_in,
  input  logic                    en,
  output logic                    tx,
  output logic                    busy,
  output logic                    fifo_full,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned CCW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef OUT_PORT_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [15:0]     mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [15:0]     last_value;

  logic [CCW-1:0]  cyc_cnt;
  logic [CCW-1:0]  cyc_next;
  logic [2:0]      bit_cnt;
  logic [2:0]      bit_next;
  logic            byte_sel;        // 1 = high byte in flight
  logic            byte_sel_next;
  logic [15:0]     shift_word;
  logic [15:0]     shift_word_next;
  logic [7:0]      cur_byte_next;

  logic            fifo_empty;
  logic            bit_done;
  logic            last_bit;
  logic            push_req;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count_next;
  logic            tx_d;
  logic            busy_d;

  assign fifo_empty = (fifo_count == '0);
  assign bit_done   = (cyc_cnt == CCW'(CLKS_PER_BIT - 1));
  assign last_bit   = (bit_cnt == 3'd7);

  // Change detect and FIFO admission; a full FIFO still accepts when a pop
  // frees a slot on the same edge.
  assign push_req   = en && (data_in != last_value);
  assign push       = push_req && (!fifo_full || pop);
  assign count_next = fifo_count + CW'(push) - CW'(pop);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!fifo_empty) state_next = S_START;
      S_START: if (bit_done) state_next = S_DATA;
      S_DATA: begin
        if (bit_done && last_bit) begin
`ifdef OUT_PORT_UART_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef OUT_PORT_UART_PARITY_EN
      S_PARITY: if (bit_done) state_next = S_STOP;
`endif
      S_STOP: begin
        if (bit_done) begin
          // Low byte still pending, or another word queued: straight to START.
          if (byte_sel || !fifo_empty) state_next = S_START;
          else                         state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output and datapath-next logic; tx/busy are computed from next-cycle
  // values so the registered line changes on the same edge as the state.
  always_comb begin
    pop             = 1'b0;
    cyc_next        = '0;
    bit_next        = bit_cnt;
    byte_sel_next   = byte_sel;
    shift_word_next = shift_word;
    cur_byte_next   = 8'h00;
    tx_d            = 1'b1;
    busy_d          = 1'b0;

    pop = ((state == S_IDLE) && !fifo_empty) ||
          ((state == S_STOP) && bit_done && !byte_sel && !fifo_empty);

    if ((state != S_IDLE) && !bit_done) cyc_next = cyc_cnt + CCW'(1);

    if (state == S_DATA) begin
      if (bit_done) bit_next = bit_cnt + 3'd1;
    end else begin
      bit_next = 3'd0;
    end

    if (pop) begin
      shift_word_next = mem[rd_ptr];
      byte_sel_next   = 1'b1;
    end else if ((state == S_STOP) && bit_done) begin
      byte_sel_next   = 1'b0;
    end

    cur_byte_next = byte_sel_next ? shift_word_next[15:8] : shift_word_next[7:0];

    case (state_next)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = cur_byte_next[bit_next];
`ifdef OUT_PORT_UART_PARITY_EN
      S_PARITY: tx_d = ^cur_byte_next;
`endif
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_next != S_IDLE) || (count_next != '0);
  end

  // FIFO storage; contents need no reset since the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= data_in;
  end

  // Pointers, flags, serializer datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      overflow   <= 1'b0;
      last_value <= 16'h0000;
      cyc_cnt    <= '0;
      bit_cnt    <= 3'd0;
      byte_sel   <= 1'b0;
      shift_word <= 16'h0000;
      tx         <= 1'b1;
      busy       <= 1'b0;
    end else begin
      // last_value tracks even dropped captures so a dropped word never retries.
      if (push_req)         last_value <= data_in;
      if (push)             wr_ptr     <= wr_ptr + PW'(1);
      if (pop)              rd_ptr     <= rd_ptr + PW'(1);
      if (push_req && !push) overflow  <= 1'b1;
      fifo_count <= count_next;
      fifo_full  <= (count_next == CW'(DEPTH));
      cyc_cnt    <= cyc_next;
      bit_cnt    <= bit_next;
      byte_sel   <= byte_sel_next;
      shift_word <= shift_word_next;
      tx         <= tx_d;
      busy       <= busy_d;
    end
  end

endmodule
